knn_voter: RTL and testbench
============================

// Module: knn_voter
// PURPOSE
//  Final KNN stage, downstream of the sorter. After a sort pass it walks the
//  K nearest neighbour indices via the sorter's SEL mux and looks up each
//  index's class in an internal label RAM that the CPU loads. It then tallies
//  votes per class and outputs the winning class with its vote count.
// PARAMETERS
//  K        4  neighbours read from the sorter; SEL_W = $clog2(K)
//  IDX_W    8  index width; label RAM depth = 2**IDX_W
//  LABEL_W  4  class width; N_CLASS = 2**LABEL_W (localparam)
// PORTS
//  clk        in   1        clock
//  rst        in   1        synchronous, active-high reset
//  start      in   1        one-cycle pulse; accepted only when busy=0
//  n_pts      in   IDX_W    training points loaded; rank r votes iff r < n_pts
//  sel        out  SEL_W    neighbour rank select, drives sorter SEL
//  idx_in     in   IDX_W    sorter index output for the current sel (same cycle)
//  lbl_we     in   1        label RAM write enable
//  lbl_addr   in   IDX_W    label RAM write address
//  lbl_wdata  in   LABEL_W  label RAM write data
//  busy       out  1        high from the cycle after start acceptance until DONE
//  vld        out  1        one-cycle pulse: label/votes valid
//  label      out  LABEL_W  winning class, held until the next start
//  votes      out  8        accumulated vote weight of the winner
// BEHAVIOUR
//  - Reset: FSM=IDLE, sel=0, busy=0, vld=0, label=0, votes=0, tallies cleared.
//    Label RAM contents are not reset.
//  - FSM: IDLE -> FETCH (K cycles, sel=0..K-1) -> DRAIN (1) -> SCAN (N_CLASS)
//    -> DONE (1, vld=1) -> IDLE.
//  - Latency: start sampled high at edge t -> vld high in the cycle after
//    edge t+K+N_CLASS+2 (22 cycles for the defaults).
//  - On start acceptance: all N_CLASS tallies cleared, first_rank[c]=K (none).
//  - FETCH: RAM read address = idx_in. Synchronous read, 1-cycle latency; the
//    label for rank r is accumulated one cycle later. DRAIN absorbs the last.
//  - Accumulate: if r < n_pts: tally[lbl] += w(r), and
//    first_rank[lbl] = min(first_rank[lbl], r). Otherwise no effect.
//  - SCAN: class c=0..N_CLASS-1, one per cycle. c replaces best if
//    tally[c] > best, or tally[c]==best>0 and first_rank[c] < best_rank.
//    Ties therefore go to the class owning the nearest neighbour.
//  - Tallies are 8 bits and never overflow for K<=15.
//  - n_pts=0: no votes; DONE still pulses vld with label=0, votes=0.
//  - start while busy or in DONE: ignored, no effect on the pass.
//  - RAM write during FETCH to the address being read: read-first (old data).
//    Writes are accepted in any state.
//  - rst mid-pass: next cycle all outputs are at reset values and the FSM is
//    IDLE. A following start runs normally.
//  - idx_in must be stable for the sorter's completed pass; the voter does not
//    observe the sorter's done signal.
// CONFIGURATION
//  KNN_VOTER_WEIGHT_EN defined: rank-weighted vote, w(r) = K - r
//    (nearest neighbour weighs K).
//  KNN_VOTER_WEIGHT_EN undefined: w(r) = 1 (plain majority).
//  Latency and interface are identical in both builds.
// TESTING
//  1 Basic: ram[3,7,9,12]={1,1,2,1}, idx by rank={3,7,9,12}, n_pts=20, start
//    -> vld 22 cycles later; label=1, votes=3 (weighted build: 8).
//  2 Tie: labels by rank {2,5,5,2} -> label=2, votes=2 (weighted: 5 vs 5 -> 2).
//  3 Weight differs: labels by rank {1,2,3,2} -> unweighted label=2, votes=2;
//    weighted 4 vs 4 tie -> label=1, votes=4.
//  4 Partial set: n_pts=2, labels {3,4,7,7} -> label=3, votes=1 (weighted: 4).
//    n_pts=0 -> label=0, votes=0, vld still pulses.
//  5 start pulsed again at FETCH rank 2 -> ignored; single vld at the original
//    cycle with the same result as test 1.
//  6 rst during SCAN -> busy=0, vld=0, label=0 next cycle. Rerun of test 1
//    without reloading the RAM -> label=1, votes=3.

Source files
------------

// File: rtl/knn_voter.sv
// knn_voter: K-nearest-neighbour class vote with CPU-loaded label RAM; KNN_VOTER_WEIGHT_EN selects rank-weighted votes
module knn_voter #(
  parameter int K = 4,
  parameter int IDX_W = 8,
  parameter int LABEL_W = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [IDX_W-1:0]       n_pts,
  output logic [$clog2(K)-1:0]   sel,
  input  logic [IDX_W-1:0]       idx_in,
  input  logic                   lbl_we,
  input  logic [IDX_W-1:0]       lbl_addr,
  input  logic [LABEL_W-1:0]     lbl_wdata,
  output logic                   busy,
  output logic                   vld,
  output logic [LABEL_W-1:0]     label,
  output logic [7:0]             votes
);
  localparam int SEL_W = $clog2(K);
  localparam int N_CLASS = 2**LABEL_W;
  localparam logic [2:0] IDLE = 3'd0, CLEAR = 3'd1, FETCH = 3'd2, DRAIN = 3'd3, SCAN = 3'd4, DONE = 3'd5;
  logic [2:0] state;
  logic [LABEL_W-1:0] ram [2**IDX_W];
  logic [LABEL_W-1:0] rd, cls;
  logic [SEL_W-1:0] rank_q;
  logic acc_v, use_acc, take;
  logic [7:0] w;
  logic [7:0] tally [N_CLASS];
  logic [SEL_W:0] first_rank [N_CLASS];
  logic [SEL_W:0] best_rank;
  assign busy = state != IDLE && state != DONE;
  assign vld = state == DONE;
  always_comb begin
`ifdef KNN_VOTER_WEIGHT_EN
    w = 8'(K) - 8'(rank_q);
`else
    w = 8'd1;
`endif
    use_acc = acc_v && IDX_W'(rank_q) < n_pts;
    take = state == SCAN && (tally[cls] > votes || (tally[cls] == votes && votes != 0 && first_rank[cls] < best_rank));
  end
  always_ff @(posedge clk) begin
    if (lbl_we) ram[lbl_addr] <= lbl_wdata;
    rd <= ram[idx_in];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      acc_v <= 1'b0;
      rank_q <= '0;
      cls <= '0;
      label <= '0;
      votes <= '0;
      best_rank <= (SEL_W+1)'(K);
      for (int i = 0; i < N_CLASS; i++) begin
        tally[i] <= '0;
        first_rank[i] <= (SEL_W+1)'(K);
      end
    end else begin
      acc_v <= state == FETCH;
      rank_q <= sel;
      if (use_acc) begin
        tally[rd] <= tally[rd] + w;
        if ({1'b0, rank_q} < first_rank[rd]) first_rank[rd] <= {1'b0, rank_q};
      end
      if (take) begin
        label <= cls;
        votes <= tally[cls];
        best_rank <= first_rank[cls];
      end
      case (state)
        IDLE: if (start) state <= CLEAR;
        CLEAR: begin
          state <= FETCH;
          sel <= '0;
          label <= '0;
          votes <= '0;
          best_rank <= (SEL_W+1)'(K);
          for (int i = 0; i < N_CLASS; i++) begin
            tally[i] <= '0;
            first_rank[i] <= (SEL_W+1)'(K);
          end
        end
        FETCH: begin
          sel <= sel == SEL_W'(K-1) ? '0 : sel + 1'b1;
          if (sel == SEL_W'(K-1)) state <= DRAIN;
        end
        DRAIN: begin
          state <= SCAN;
          cls <= '0;
        end
        SCAN: begin
          cls <= cls + 1'b1;
          if (cls == LABEL_W'(N_CLASS-1)) state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_knn_voter.sv
// tb_knn_voter: scoreboarded bench for knn_voter using a behavioural sorter and vote model
module tb_knn_voter;
  localparam int K = 4;
  logic clk = 1'b0;
  logic rst, start, lbl_we, busy, vld;
  logic [7:0] n_pts, idx_in, lbl_addr, votes;
  logic [3:0] lbl_wdata, label;
  logic [1:0] sel;
  logic [7:0] ranks [K];
  logic [3:0] shadow [256];
  logic [11:0] exp_q [$];
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  assign idx_in = ranks[sel];
  knn_voter dut (
    .clk(clk), .rst(rst), .start(start), .n_pts(n_pts), .sel(sel), .idx_in(idx_in),
    .lbl_we(lbl_we), .lbl_addr(lbl_addr), .lbl_wdata(lbl_wdata),
    .busy(busy), .vld(vld), .label(label), .votes(votes)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic wr(input logic [7:0] a, input logic [3:0] d);
    @(negedge clk);
    lbl_we = 1'b1;
    lbl_addr = a;
    lbl_wdata = d;
    shadow[a] = d;
    @(negedge clk);
    lbl_we = 1'b0;
  endtask
  task automatic setup(input logic [7:0] i0, i1, i2, i3, input logic [3:0] l0, l1, l2, l3);
    ranks[0] = i0; ranks[1] = i1; ranks[2] = i2; ranks[3] = i3;
    wr(i0, l0); wr(i1, l1); wr(i2, l2); wr(i3, l3);
  endtask
  function automatic logic [11:0] model(input logic [7:0] n);
    int tl [16];
    int fr [16];
    int bv, br, bl, lb;
    for (int c = 0; c < 16; c++) begin
      tl[c] = 0;
      fr[c] = K;
    end
    for (int r = 0; r < K; r++)
      if (r < int'(n)) begin
        lb = int'(shadow[ranks[r]]);
`ifdef KNN_VOTER_WEIGHT_EN
        tl[lb] += K - r;
`else
        tl[lb] += 1;
`endif
        if (r < fr[lb]) fr[lb] = r;
      end
    bv = 0; br = K; bl = 0;
    for (int c = 0; c < 16; c++)
      if (tl[c] > bv || (tl[c] == bv && bv > 0 && fr[c] < br)) begin
        bl = c; bv = tl[c]; br = fr[c];
      end
    return {4'(bl), 8'(bv)};
  endfunction
  task automatic run(input string tag, input logic [7:0] n, input int restart_at);
    int cnt, extra;
    logic [11:0] e;
    n_pts = n;
    exp_q.push_back(model(n));
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk);
      if (cnt == 0) check({tag, "_busy"}, busy, 1);
      if (vld) break;
      start = (cnt == restart_at);
      cnt++;
    end
    start = 1'b0;
    check({tag, "_latency"}, cnt, 22);
    e = exp_q.pop_front();
    if (vld) begin
      check({tag, "_label"}, label, e[11:8]);
      check({tag, "_votes"}, votes, e[7:0]);
    end
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (vld) extra++;
    end
    check({tag, "_single_vld"}, extra, 0);
    check({tag, "_label_held"}, label, e[11:8]);
  endtask
  initial begin
    rst = 1'b1; start = 1'b0; lbl_we = 1'b0; n_pts = '0; lbl_addr = '0; lbl_wdata = '0;
    for (int i = 0; i < K; i++) ranks[i] = '0;
    for (int i = 0; i < 256; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_vld", vld, 0);
    check("rst_sel", sel, 0);
    check("rst_label", label, 0);
    check("rst_votes", votes, 0);
    rst = 1'b0;
    setup(8'd3, 8'd7, 8'd9, 8'd12, 4'd1, 4'd1, 4'd2, 4'd1);
    run("basic", 8'd20, -1);
    setup(8'd20, 8'd21, 8'd22, 8'd23, 4'd2, 4'd5, 4'd5, 4'd2);
    run("tie", 8'd20, -1);
    setup(8'd30, 8'd31, 8'd32, 8'd33, 4'd1, 4'd2, 4'd3, 4'd2);
    run("weight", 8'd20, -1);
    setup(8'd40, 8'd41, 8'd42, 8'd43, 4'd3, 4'd4, 4'd7, 4'd7);
    run("partial", 8'd2, -1);
    run("empty", 8'd0, -1);
    ranks[0] = 8'd3; ranks[1] = 8'd7; ranks[2] = 8'd9; ranks[3] = 8'd12;
    run("restart", 8'd20, 3);
    n_pts = 8'd20;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_vld", vld, 0);
    check("abort_label", label, 0);
    check("abort_votes", votes, 0);
    check("abort_sel", sel, 0);
    rst = 1'b0;
    run("rerun", 8'd20, -1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
